// File: rtl/ohc5_pkg.sv
// Shared definitions for the one-hot mod-5 residue datapath.
// Used by ohc5_add_core and ohc5_adder_arbiter.
package ohc5_pkg;

  localparam int RES_W = 5;
  localparam int MOD   = 5;

  typedef logic [RES_W-1:0] ohc5_t;

  // one-hot encoding of residue 0
  localparam ohc5_t OHC5_ZERO = 5'b00001;

  // true when exactly one residue bit is set
  function automatic logic ohc5_is_onehot(input ohc5_t v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/ohc5_add_core.sv
// Combinational one-hot mod-5 adder: sum = onehot((idx(a) + idx(b)) mod 5).
// Operands that are not one-hot give an undefined (but deterministic) result.
module ohc5_add_core
  import ohc5_pkg::*;
(
  input  ohc5_t a,
  input  ohc5_t b,
  output ohc5_t sum
);

  logic [2:0] ia;
  logic [2:0] ib;
  logic [3:0] s;

  // decode both operands to residue indices, add, fold back into 0..4
  always_comb begin
    ia = '0;
    ib = '0;
    for (int k = 0; k < RES_W; k++) begin
      if (a[k]) ia = 3'(k);
      if (b[k]) ib = 3'(k);
    end
    s = {1'b0, ia} + {1'b0, ib};
    if (s >= 4'(MOD)) s = s - 4'(MOD);
    sum = ohc5_t'(5'b00001 << s);
  end

endmodule

// File: rtl/ohc5_adder_arbiter.sv
// Round-robin arbiter sharing one ohc5_add_core among NUM_REQ requesters,
// with a single registered response slot tagged by requester index.
// Optional macro OHC5_ONEHOT_CHECK_EN adds rsp_err for non-one-hot operands.
//
// Slot FSM states:
//   state   | meaning
//   S_EMPTY | no response held; any valid requester can be accepted
//   S_FULL  | rsp_sum/rsp_id hold a result awaiting rsp_ready
module ohc5_adder_arbiter
  import ohc5_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*RES_W-1:0] req_a,
  input  logic [NUM_REQ*RES_W-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output ohc5_t                    rsp_sum,
  output logic [ID_W-1:0]          rsp_id,
`ifdef OHC5_ONEHOT_CHECK_EN
  output logic                     rsp_err,
`endif
  output logic                     busy
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_state_t;

  slot_state_t     state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] ptr_next;
  logic            grant_found;
  logic            can_accept;
  logic            accept;
  ohc5_t           sel_a;
  ohc5_t           sel_b;
  ohc5_t           core_sum;
  ohc5_t           next_sum;
  int              j;

  assign rsp_valid  = (state == S_FULL);
  assign can_accept = !rsp_valid || rsp_ready;
  assign busy       = rsp_valid || (|req_valid);

  // first valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(rr_ptr) + i) % NUM_REQ;
      if (!grant_found && req_valid[j]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
  end

  assign accept   = grant_found && can_accept;
  assign ptr_next = ID_W'((int'(grant_idx) + 1) % NUM_REQ);

  // ready goes only to the granted requester, and only when the slot can take it
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  assign sel_a = req_a[int'(grant_idx)*RES_W +: RES_W];
  assign sel_b = req_b[int'(grant_idx)*RES_W +: RES_W];

  ohc5_add_core u_core (
    .a   (sel_a),
    .b   (sel_b),
    .sum (core_sum)
  );

`ifdef OHC5_ONEHOT_CHECK_EN
  logic op_bad;
  assign op_bad   = !ohc5_is_onehot(sel_a) || !ohc5_is_onehot(sel_b);
  assign next_sum = op_bad ? ohc5_t'('0) : core_sum;
`else
  assign next_sum = core_sum;
`endif

  // slot FSM, response registers and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_EMPTY;
      rsp_sum <= '0;
      rsp_id  <= '0;
      rr_ptr  <= '0;
`ifdef OHC5_ONEHOT_CHECK_EN
      rsp_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_EMPTY: if (accept) state <= S_FULL;
        S_FULL:  if (rsp_ready && !accept) state <= S_EMPTY;
        default: state <= S_EMPTY;
      endcase
      if (accept) begin
        rsp_sum <= next_sum;
        rsp_id  <= grant_idx;
        rr_ptr  <= ptr_next;
`ifdef OHC5_ONEHOT_CHECK_EN
        rsp_err <= op_bad;
`endif
      end
    end
  end

endmodule
